// File: rtl/adc_channel_scanner_pkg.sv
// Shared widths and FSM state encoding for the ADC channel scanner.
package adc_channel_scanner_pkg;
  localparam int ADC_W    = 10;
  localparam int ADC_CH_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_PUBLISH = 2'd3
  } scan_state_t;
endpackage

// File: rtl/adc_channel_scanner_avg_accum.sv
// Sample accumulator: sums 2^AVG_LOG2 samples and flags the add that completes the set.
module adc_avg_accum
  import adc_channel_scanner_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_add,
  input  logic [ADC_W-1:0]          i_sample,
  output logic [ADC_W+AVG_LOG2-1:0] o_sum_next,
  output logic                      o_last
);
  localparam int SUM_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;

  // Sum including the current sample, so the average is ready on the completing edge.
  assign o_sum_next = r_sum + SUM_W'(i_sample);
  assign o_last     = i_add && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      r_sum <= o_sum_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/adc_channel_scanner.sv
// Round-robin ADC channel scanner with settle-discard, averaging and a per-channel result bank.
// Optional per-channel threshold alarm (over_thresh) enabled by defining ADC_SCAN_ALARM_EN.
module adc_channel_scanner
  import adc_channel_scanner_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int DISCARD  = 1,
  parameter int THRESH   = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic [ADC_CH_W-1:0]     channel,
  input  logic                    new_sample,
  input  logic [ADC_W-1:0]        sample,
  input  logic [ADC_CH_W-1:0]     sample_channel,
  output logic                    avg_valid,
  output logic [ADC_CH_W-1:0]     avg_channel,
  output logic [ADC_W-1:0]        avg_value,
`ifdef ADC_SCAN_ALARM_EN
  output logic [ADC_W*NUM_CH-1:0] ch_value,
  output logic [NUM_CH-1:0]       over_thresh
`else
  output logic [ADC_W*NUM_CH-1:0] ch_value
`endif
);
  localparam logic [ADC_CH_W-1:0] CH_LAST     = ADC_CH_W'(NUM_CH - 1);
  localparam logic [3:0]          DISC_LAST   = 4'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam bit                  SKIP_SETTLE = (DISCARD == 0);

  scan_state_t r_state, w_state_next;

  logic [ADC_CH_W-1:0]        r_channel;
  logic [3:0]                 r_disc_cnt;
  logic                       r_avg_valid;
  logic [ADC_CH_W-1:0]        r_avg_channel;
  logic [ADC_W-1:0]           r_avg_value;
  logic [ADC_W*NUM_CH-1:0]    r_ch_value;

  logic                       w_accept;
  logic                       w_clear;
  logic                       w_add;
  logic                       w_last;
  logic                       w_publish_go;
  logic                       w_disc_inc;
  logic                       w_disc_clr;
  logic [ADC_W+AVG_LOG2-1:0]  w_sum_next;
  logic [ADC_W-1:0]           w_avg_next;

  assign w_accept   = new_sample && (sample_channel == r_channel);
  assign w_avg_next = ADC_W'(w_sum_next >> AVG_LOG2);

  adc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_add      (w_add),
    .i_sample   (sample),
    .o_sum_next (w_sum_next),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_add        = 1'b0;
    w_publish_go = 1'b0;
    w_disc_inc   = 1'b0;
    w_disc_clr   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_clear    = 1'b1;
        w_disc_clr = 1'b1;
        if (enable) w_state_next = SKIP_SETTLE ? ST_ACCUM : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!enable) begin
          w_state_next = ST_IDLE;
        end else if (w_accept) begin
          if (r_disc_cnt == DISC_LAST) begin
            w_state_next = ST_ACCUM;
            w_disc_clr   = 1'b1;
          end else begin
            w_disc_inc = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          w_state_next = ST_IDLE;
        end else if (w_accept) begin
          w_add = 1'b1;
          if (w_last) begin
            w_state_next = ST_PUBLISH;
            w_publish_go = 1'b1;
          end
        end
      end
      ST_PUBLISH: begin
        // The publish itself was latched on entry; this cycle only rolls to the next channel.
        w_clear      = 1'b1;
        w_disc_clr   = 1'b1;
        w_state_next = !enable ? ST_IDLE : (SKIP_SETTLE ? ST_ACCUM : ST_SETTLE);
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_channel     <= '0;
      r_disc_cnt    <= '0;
      r_avg_valid   <= 1'b0;
      r_avg_channel <= '0;
      r_avg_value   <= '0;
      r_ch_value    <= '0;
    end else begin
      r_avg_valid <= w_publish_go;
      if (w_disc_clr)      r_disc_cnt <= '0;
      else if (w_disc_inc) r_disc_cnt <= r_disc_cnt + 1'b1;
      if (w_state_next == ST_IDLE)  r_channel <= '0;
      else if (r_state == ST_PUBLISH) r_channel <= (r_channel == CH_LAST) ? '0 : r_channel + 1'b1;
      if (w_publish_go) begin
        r_avg_channel <= r_channel;
        r_avg_value   <= w_avg_next;
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_channel == ADC_CH_W'(i)) r_ch_value[i*ADC_W +: ADC_W] <= w_avg_next;
        end
      end
    end
  end

  assign channel     = r_channel;
  assign avg_valid   = r_avg_valid;
  assign avg_channel = r_avg_channel;
  assign avg_value   = r_avg_value;
  assign ch_value    = r_ch_value;

`ifdef ADC_SCAN_ALARM_EN
  logic [NUM_CH-1:0] r_over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_over <= '0;
    end else if (w_state_next == ST_IDLE) begin
      r_over <= '0;
    end else if (w_publish_go) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_channel == ADC_CH_W'(i)) r_over[i] <= (w_avg_next >= ADC_W'(THRESH));
      end
    end
  end

  assign over_thresh = r_over;
`endif
endmodule

// File: tb/tb_adc_channel_scanner.sv
// Directed bench for adc_channel_scanner: two instances (2-channel/avg4/discard1 and 1-channel/avg64/no discard).
module tb_adc_channel_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_a, ns_a, en_b, ns_b;
  logic [9:0] s_a, s_b;
  logic [3:0] sc_a, sc_b;

  logic [3:0]  ch_a, avgch_a, ch_b, avgch_b;
  logic        avgv_a, avgv_b;
  logic [9:0]  avgval_a, avgval_b;
  logic [19:0] chv_a;
  logic [9:0]  chv_b;
`ifdef ADC_SCAN_ALARM_EN
  logic [1:0]  ot_a;
  logic [0:0]  ot_b;
`endif

  adc_channel_scanner #(.NUM_CH(2), .AVG_LOG2(2), .DISCARD(1), .THRESH(512)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .channel(ch_a),
    .new_sample(ns_a), .sample(s_a), .sample_channel(sc_a),
    .avg_valid(avgv_a), .avg_channel(avgch_a), .avg_value(avgval_a),
`ifdef ADC_SCAN_ALARM_EN
    .ch_value(chv_a), .over_thresh(ot_a)
`else
    .ch_value(chv_a)
`endif
  );

  adc_channel_scanner #(.NUM_CH(1), .AVG_LOG2(6), .DISCARD(0), .THRESH(512)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .channel(ch_b),
    .new_sample(ns_b), .sample(s_b), .sample_channel(sc_b),
    .avg_valid(avgv_b), .avg_channel(avgch_b), .avg_value(avgval_b),
`ifdef ADC_SCAN_ALARM_EN
    .ch_value(chv_b), .over_thresh(ot_b)
`else
    .ch_value(chv_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pub_a  = 0;
  int n_pub_b  = 0;
  int n_push_a = 0;
  int n_push_b = 0;

  logic [13:0] exp_a[$];
  logic [13:0] exp_b[$];
  logic [13:0] e_a, e_b;
  logic [9:0]  exp_chv[2];
  logic [1:0]  exp_ot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every published average must match the oldest queued expectation.
  always @(negedge clk) begin
    if (avgv_a === 1'b1) begin
      n_pub_a++;
      n_checks++;
      assert (exp_a.size() != 0) else begin
        n_errors++;
        $error("FAIL pub_a_unexpected: observed ch %0d value %0d expected no publish", avgch_a, avgval_a);
      end
      if (exp_a.size() != 0) begin
        e_a = exp_a.pop_front();
        chk("pub_a", {18'd0, avgch_a, avgval_a}, {18'd0, e_a});
      end
    end
    if (avgv_b === 1'b1) begin
      n_pub_b++;
      n_checks++;
      assert (exp_b.size() != 0) else begin
        n_errors++;
        $error("FAIL pub_b_unexpected: observed ch %0d value %0d expected no publish", avgch_b, avgval_b);
      end
      if (exp_b.size() != 0) begin
        e_b = exp_b.pop_front();
        chk("pub_b", {18'd0, avgch_b, avgval_b}, {18'd0, e_b});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [3:0] sch, input logic [9:0] v);
    ns_a = 1'b1; sc_a = sch; s_a = v;
    tick();
    ns_a = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] v);
    ns_b = 1'b1; sc_b = 4'd0; s_b = v;
    tick();
    ns_b = 1'b0;
  endtask

  // One full visit of dut_a on channel ch with stray strobes mixed in.
  task automatic visit_a(input logic [3:0] ch, input int v0, input int v1, input int v2, input int v3);
    int         sum;
    logic [9:0] avg;
    send_a(ch ^ 4'd1, 10'd1023);
    send_a(ch, 10'd1000);
    send_a(4'd3, 10'd1023);
    send_a(ch, 10'(v0));
    send_a(ch, 10'(v1));
    send_a(ch ^ 4'd1, 10'd1023);
    send_a(ch, 10'(v2));
    sum = v0 + v1 + v2 + v3;
    avg = 10'(sum / 4);
    exp_a.push_back({ch, avg});
    n_push_a++;
    exp_chv[ch[0]] = avg;
    exp_ot[ch[0]]  = (avg >= 10'd512);
    send_a(ch, 10'(v3));
    chk("valid_in_publish", {31'd0, avgv_a}, 32'd1);
    tick();
    chk("valid_after_publish", {31'd0, avgv_a}, 32'd0);
    chk("channel_advance", {28'd0, ch_a}, (ch == 4'd1) ? 32'd0 : 32'd1);
    chk("ch_value_bank", {12'd0, chv_a}, {12'd0, exp_chv[1], exp_chv[0]});
    chk("avg_value_hold", {22'd0, avgval_a}, {22'd0, avg});
`ifdef ADC_SCAN_ALARM_EN
    chk("over_thresh_a", {30'd0, ot_a}, {30'd0, exp_ot});
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; ns_a = 1'b0; s_a = '0; sc_a = '0;
    en_b = 1'b0; ns_b = 1'b0; s_b = '0; sc_b = '0;
    exp_chv[0] = '0; exp_chv[1] = '0; exp_ot = '0;
    repeat (3) tick();
    chk("rst_channel_a", {28'd0, ch_a}, 32'd0);
    chk("rst_valid_a", {31'd0, avgv_a}, 32'd0);
    chk("rst_avg_value_a", {22'd0, avgval_a}, 32'd0);
    chk("rst_ch_value_a", {12'd0, chv_a}, 32'd0);
    chk("rst_ch_value_b", {22'd0, chv_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Disabled: accepted-looking strobes must not publish anything.
    repeat (6) send_a(4'd0, 10'd900);
    chk("idle_channel_a", {28'd0, ch_a}, 32'd0);
    en_a = 1'b1;
    tick();

    visit_a(4'd0, 10, 20, 30, 41);
    visit_a(4'd1, 200, 300, 400, 503);
    visit_a(4'd0, 600, 600, 600, 604);

    // Abort a ch1 visit after two accumulated samples.
    send_a(4'd1, 10'd1000);
    send_a(4'd1, 10'd100);
    send_a(4'd1, 10'd100);
    en_a = 1'b0;
    tick();
    chk("drop_channel", {28'd0, ch_a}, 32'd0);
    chk("drop_valid", {31'd0, avgv_a}, 32'd0);
    chk("drop_ch_value", {12'd0, chv_a}, {12'd0, exp_chv[1], exp_chv[0]});
    exp_ot = '0;
`ifdef ADC_SCAN_ALARM_EN
    chk("drop_over_thresh", {30'd0, ot_a}, 32'd0);
`endif
    repeat (2) tick();
    en_a = 1'b1;
    tick();
    visit_a(4'd0, 700, 700, 700, 700);
    visit_a(4'd1, 512, 512, 512, 512);
    visit_a(4'd0, 500, 500, 500, 503);

    // Asynchronous reset in the middle of a visit.
    send_a(4'd1, 10'd1000);
    send_a(4'd1, 10'd50);
    send_a(4'd1, 10'd60);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_channel", {28'd0, ch_a}, 32'd0);
    chk("midrst_valid", {31'd0, avgv_a}, 32'd0);
    chk("midrst_ch_value", {12'd0, chv_a}, 32'd0);
    chk("midrst_avg_value", {22'd0, avgval_a}, 32'd0);
    exp_chv[0] = '0; exp_chv[1] = '0; exp_ot = '0;
    en_a = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) send_a(4'd0, 10'd800);
    chk("postrst_ch_value", {12'd0, chv_a}, 32'd0);
    en_a = 1'b1;
    tick();
    visit_a(4'd0, 1, 2, 3, 5);

    // dut_b: 64-sample average, no settling discard, single channel.
    en_b = 1'b1;
    tick();
    for (int i = 0; i < 63; i++) send_b(10'd1023);
    exp_b.push_back({4'd0, 10'd1023});
    n_push_b++;
    send_b(10'd1023);
    chk("b_valid_full_scale", {31'd0, avgv_b}, 32'd1);
    // A strobe during the publish cycle must be dropped.
    send_b(10'd1023);
    chk("b_channel_stays0", {28'd0, ch_b}, 32'd0);
    chk("b_ch_value_full", {22'd0, chv_b}, 32'd1023);
`ifdef ADC_SCAN_ALARM_EN
    chk("b_over_thresh_hi", {31'd0, ot_b}, 32'd1);
`endif
    for (int i = 0; i < 63; i++) send_b(10'(i));
    exp_b.push_back({4'd0, 10'd31});
    n_push_b++;
    send_b(10'd63);
    chk("b_valid_ramp", {31'd0, avgv_b}, 32'd1);
    tick();
    chk("b_ch_value_ramp", {22'd0, chv_b}, 32'd31);
    chk("b_channel_after", {28'd0, ch_b}, 32'd0);
`ifdef ADC_SCAN_ALARM_EN
    chk("b_over_thresh_lo", {31'd0, ot_b}, 32'd0);
`endif

    repeat (3) tick();
    chk("queue_a_drained", 32'(exp_a.size()), 32'd0);
    chk("queue_b_drained", 32'(exp_b.size()), 32'd0);
    chk("publish_count_a", 32'(n_pub_a), 32'(n_push_a));
    chk("publish_count_b", 32'(n_pub_b), 32'(n_push_b));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
